// File: rtl/outerprodrc_acc_pkg.sv
// Shared definitions for the outer-product rate-coded accumulator tile.
// Contents: FSM state encoding, bit-reversal and saturating-add helpers,
// and the default magnitude width M.
package outerprodrc_pkg;

  localparam int unsigned DEF_BITWIDTH = 8;
  localparam int unsigned M            = DEF_BITWIDTH - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Reverse the low n bits of x; bits above n are returned as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] x, input int n);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) y[i] = x[n-1-i];
    end
    return y;
  endfunction

  // a + b clamped to the signed range of a w-bit two's-complement value (w <= 31).
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi)      s = hi;
    else if (s < lo) s = lo;
    return 32'(s);
  endfunction

endpackage

// File: rtl/outerprodrc_acc_if.sv
// Handshake and operand/result bus of the outer-product accumulator tile.
// master: drives iEn/iClr/iStart/iData0/iData1, observes oBusy/oDone/oData.
// slave : the tile itself.
interface outerprodrc_acc_if #(
  parameter int unsigned ROWNUM      = 4,
  parameter int unsigned COLNUM      = 4,
  parameter int unsigned HIDDEN      = 4,
  parameter int unsigned BITWIDTH    = 8,
  parameter int unsigned OUTBITWIDTH = 16
);
  logic                                 iEn;
  logic                                 iClr;
  logic                                 iStart;
  logic [HIDDEN*ROWNUM*BITWIDTH-1:0]    iData0;
  logic [HIDDEN*COLNUM*BITWIDTH-1:0]    iData1;
  logic                                 oBusy;
  logic                                 oDone;
  logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0] oData;

  modport master (
    output iEn, iClr, iStart, iData0, iData1,
    input  oBusy, oDone, oData
  );

  modport slave (
    input  iEn, iClr, iStart, iData0, iData1,
    output oBusy, oDone, oData
  );
endinterface

// File: rtl/outerprodrc_acc_cell.sv
// One output cell: sums HIDDEN signed unary AND-products per cycle and keeps a
// saturating accumulator.
// Ports: iClk/iRst clock and async reset; en advances the accumulator; clr zeroes
// it; row_bits/col_bits/neg_bits per lane; acc_nxt_c is the value the
// accumulator takes at the next edge (combinational).
module outerprodrc_acc_cell
  import outerprodrc_pkg::*;
#(
  parameter int unsigned HIDDEN      = 4,
  parameter int unsigned OUTBITWIDTH = 16
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          en,
  input  logic                          clr,
  input  logic [HIDDEN-1:0]             row_bits,
  input  logic [HIDDEN-1:0]             col_bits,
  input  logic [HIDDEN-1:0]             neg_bits,
  output logic signed [OUTBITWIDTH-1:0] acc_nxt_c
);

  logic signed [OUTBITWIDTH-1:0] acc_q;
  logic signed [OUTBITWIDTH-1:0] acc_d;
  logic signed [31:0]            delta;

  // Signed lane sum, then saturating update.
  always_comb begin
    delta = '0;
    for (int k = 0; k < int'(HIDDEN); k++) begin
      if (row_bits[k] && col_bits[k]) begin
        delta = neg_bits[k] ? (delta - 32'sd1) : (delta + 32'sd1);
      end
    end
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = OUTBITWIDTH'(sat_add(32'(acc_q), delta, int'(OUTBITWIDTH)));
    end
  end

  assign acc_nxt_c = acc_d;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

endmodule

// File: rtl/outerprodrc_acc.sv
// Outer-product unary GEMM tile with rate-coded operand streams.
// Latches sign-magnitude row/column operands on start, streams them for
// 2^(BITWIDTH-1) enabled cycles (temporal code for rows, bit-reversed code for
// columns) and accumulates signed AND-products per cell with saturation.
// Ports: iClk, iRst (async, active-high); bus (slave): iEn, iClr, iStart,
// iData0, iData1 in; oBusy, oDone, oData out (all registered).
module outerprodrc_acc
  import outerprodrc_pkg::*;
#(
  parameter int unsigned ROWNUM      = 4,
  parameter int unsigned COLNUM      = 4,
  parameter int unsigned HIDDEN      = 4,
  parameter int unsigned BITWIDTH    = 8,
  parameter int unsigned OUTBITWIDTH = 16
) (
  input logic              iClk,
  input logic              iRst,
  outerprodrc_acc_if.slave bus
);

  localparam int unsigned MAG_W  = BITWIDTH - 1;
  localparam int unsigned ROW_W  = HIDDEN * ROWNUM * BITWIDTH;
  localparam int unsigned COL_W  = HIDDEN * COLNUM * BITWIDTH;
  localparam int unsigned DATA_W = ROWNUM * COLNUM * OUTBITWIDTH;

  state_t            state_q, state_d;
  logic [MAG_W-1:0]  t_q, t_d;
  logic [ROW_W-1:0]  a_q, a_d;
  logic [COL_W-1:0]  b_q, b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic                     run_en;
  logic [MAG_W-1:0]         t_rev;
  logic [HIDDEN*ROWNUM-1:0] row_bit, row_sgn;
  logic [HIDDEN*COLNUM-1:0] col_bit, col_sgn;
  logic [DATA_W-1:0]        acc_nxt_all;

  assign t_rev = MAG_W'(bitrev(32'(t_q), int'(MAG_W)));

  // Row streams: temporal code, high for the first |a| counts.
  for (genvar k = 0; k < HIDDEN; k++) begin : g_row_lane
    for (genvar i = 0; i < ROWNUM; i++) begin : g_row
      localparam int unsigned IDX = k * ROWNUM + i;
      assign row_bit[IDX] = (t_q < a_q[IDX*BITWIDTH +: MAG_W]);
      assign row_sgn[IDX] = a_q[IDX*BITWIDTH + BITWIDTH - 1];
    end
  end

  // Column streams: compare against the bit-reversed count to spread ones evenly.
  for (genvar k = 0; k < HIDDEN; k++) begin : g_col_lane
    for (genvar j = 0; j < COLNUM; j++) begin : g_col
      localparam int unsigned IDX = k * COLNUM + j;
      assign col_bit[IDX] = (t_rev < b_q[IDX*BITWIDTH +: MAG_W]);
      assign col_sgn[IDX] = b_q[IDX*BITWIDTH + BITWIDTH - 1];
    end
  end

  // Cell array.
  for (genvar i = 0; i < ROWNUM; i++) begin : g_cell_row
    for (genvar j = 0; j < COLNUM; j++) begin : g_cell_col
      logic [HIDDEN-1:0] rb, cb, nb;
      for (genvar k = 0; k < HIDDEN; k++) begin : g_lane
        assign rb[k] = row_bit[k*ROWNUM + i];
        assign cb[k] = col_bit[k*COLNUM + j];
        assign nb[k] = row_sgn[k*ROWNUM + i] ^ col_sgn[k*COLNUM + j];
      end
      outerprodrc_acc_cell #(
        .HIDDEN      (HIDDEN),
        .OUTBITWIDTH (OUTBITWIDTH)
      ) u_cell (
        .iClk      (iClk),
        .iRst      (iRst),
        .en        (run_en),
        .clr       (bus.iClr),
        .row_bits  (rb),
        .col_bits  (cb),
        .neg_bits  (nb),
        .acc_nxt_c (acc_nxt_all[(i*COLNUM + j)*OUTBITWIDTH +: OUTBITWIDTH])
      );
    end
  end

  // Control FSM, stream counter and operand capture; clear overrides everything.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    data_d  = data_q;
    run_en  = 1'b0;
    if (bus.iClr) begin
      state_d = ST_IDLE;
      t_d     = '0;
      busy_d  = 1'b0;
      data_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.iStart) begin
            state_d = ST_RUN;
            t_d     = '0;
            a_d     = bus.iData0;
            b_d     = bus.iData1;
            busy_d  = 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.iEn) begin
            run_en = 1'b1;
            t_d    = t_q + MAG_W'(1);
            if (t_q == '1) begin
              // Publish the accumulators including this last update.
              data_d  = acc_nxt_all;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end

  assign bus.oBusy = busy_q;
  assign bus.oDone = done_q;
  assign bus.oData = data_q;

endmodule

// File: tb/tb_outerprodrc_acc.sv
// Directed bench for outerprodrc_acc: 2x2 tile, 2 lanes, 4-bit operands.
// dut8 uses 8-bit cells, dut4 uses 4-bit cells for saturation; both share stimulus.
module tb_outerprodrc_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clr;
  logic        start;
  logic [15:0] d0;
  logic [15:0] d1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  outerprodrc_acc_if #(.ROWNUM(2), .COLNUM(2), .HIDDEN(2), .BITWIDTH(4), .OUTBITWIDTH(8)) bus8 ();
  outerprodrc_acc_if #(.ROWNUM(2), .COLNUM(2), .HIDDEN(2), .BITWIDTH(4), .OUTBITWIDTH(4)) bus4 ();

  assign bus8.iEn    = en;
  assign bus8.iClr   = clr;
  assign bus8.iStart = start;
  assign bus8.iData0 = d0;
  assign bus8.iData1 = d1;
  assign bus4.iEn    = en;
  assign bus4.iClr   = clr;
  assign bus4.iStart = start;
  assign bus4.iData0 = d0;
  assign bus4.iData1 = d1;

  outerprodrc_acc #(.ROWNUM(2), .COLNUM(2), .HIDDEN(2), .BITWIDTH(4), .OUTBITWIDTH(8)) dut8 (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus8)
  );

  outerprodrc_acc #(.ROWNUM(2), .COLNUM(2), .HIDDEN(2), .BITWIDTH(4), .OUTBITWIDTH(4)) dut4 (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus4)
  );

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One epoch from IDLE with iEn high; checks handshake timing.
  task automatic epoch(input string tag);
    int cyc;
    int gaps;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc  = 1;
    gaps = 0;
    while (bus8.oDone !== 1'b1 && cyc < 40) begin
      if (bus8.oBusy !== 1'b1) gaps++;
      tick();
      cyc++;
    end
    chk({tag, " done_cycle"}, 64'(cyc), 64'd9);
    chk({tag, " busy_gaps"}, 64'(gaps), 64'd0);
    chk({tag, " busy_at_done"}, 64'(bus8.oBusy), 64'd1);
    tick();
    chk({tag, " done_pulse_end"}, 64'(bus8.oDone), 64'd0);
    chk({tag, " idle_busy"}, 64'(bus8.oBusy), 64'd0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    int cyc;
    int cnt;
    int dn;

    // d0 nibbles: {lane1 row1, lane1 row0, lane0 row1, lane0 row0}; oData bytes: {c11,c10,c01,c00}
    vecs[0] = '{d0: 16'h4444, d1: 16'h4444, exp: 32'h04040404}; // basic
    vecs[1] = '{d0: 16'hCCCC, d1: 16'h4444, exp: 32'hFCFCFCFC}; // negative rows
    vecs[2] = '{d0: 16'h44CC, d1: 16'h4444, exp: 32'h00000000}; // lanes cancel
    vecs[3] = '{d0: 16'h4488, d1: 16'h4444, exp: 32'h02020202}; // negative zero lane
    vecs[4] = '{d0: 16'h0027, d1: 16'h00D3, exp: 32'hFE01FB03}; // non-uniform, mixed signs
    vecs[5] = '{d0: 16'h7727, d1: 16'h77D3, exp: 32'h0508020A}; // plus a full lane

    rst = 1'b1; en = 1'b1; clr = 1'b0; start = 1'b0; d0 = '0; d1 = '0;
    tick();
    tick();
    chk("reset oData", 64'(bus8.oData), 64'd0);
    chk("reset oBusy", 64'(bus8.oBusy), 64'd0);
    chk("reset oDone", 64'(bus8.oDone), 64'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      d0 = vecs[v].d0;
      d1 = vecs[v].d1;
      pulse_clr();
      chk($sformatf("vec%0d cleared", v), 64'(bus8.oData), 64'd0);
      epoch($sformatf("vec%0d", v));
      chk($sformatf("vec%0d oData", v), 64'(bus8.oData), 64'(vecs[v].exp));
    end

    // Multi-epoch accumulation, then clear, then clear+start in IDLE.
    d0 = 16'h4444; d1 = 16'h4444;
    pulse_clr();
    epoch("acc1");
    chk("acc1 oData", 64'(bus8.oData), 64'h04040404);
    epoch("acc2");
    epoch("acc3");
    chk("acc3 oData", 64'(bus8.oData), 64'h0C0C0C0C);
    pulse_clr();
    chk("acc clr oData", 64'(bus8.oData), 64'd0);
    clr = 1'b1; start = 1'b1;
    tick();
    clr = 1'b0; start = 1'b0;
    cnt = 0; dn = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus8.oBusy) cnt++;
      if (bus8.oDone) dn++;
      tick();
    end
    chk("clr_start busy", 64'(cnt), 64'd0);
    chk("clr_start done", 64'(dn), 64'd0);

    // Clear mid-run aborts without a done pulse.
    epoch("pre_abort");
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    pulse_clr();
    chk("abort busy", 64'(bus8.oBusy), 64'd0);
    chk("abort oData", 64'(bus8.oData), 64'd0);
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus8.oDone) dn++;
      tick();
    end
    chk("abort done", 64'(dn), 64'd0);

    // Asynchronous reset mid-run; accumulators must restart from zero.
    epoch("pre_reset");
    chk("pre_reset oData", 64'(bus8.oData), 64'h04040404);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("midrun reset oData", 64'(bus8.oData), 64'd0);
    chk("midrun reset oBusy", 64'(bus8.oBusy), 64'd0);
    chk("midrun reset oDone", 64'(bus8.oDone), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    epoch("post_reset");
    chk("post_reset oData", 64'(bus8.oData), 64'h04040404);

    // Stall for 3 cycles and pulse start during RUN.
    pulse_clr();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (bus8.oDone !== 1'b1 && cyc < 60) begin
      en    = !(cyc >= 3 && cyc <= 5);
      start = (cyc == 6);
      tick();
      cyc++;
    end
    en = 1'b1; start = 1'b0;
    chk("stall done_cycle", 64'(cyc), 64'd12);
    chk("stall oData", 64'(bus8.oData), 64'h04040404);
    cnt = 0; dn = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (bus8.oBusy) cnt++;
      if (bus8.oDone) dn++;
    end
    chk("stall no_second busy", 64'(cnt), 64'd0);
    chk("stall no_second done", 64'(dn), 64'd0);

    // Saturation: 14 per epoch clamps to 7 in 4-bit cells.
    d0 = 16'h7777; d1 = 16'h7777;
    pulse_clr();
    epoch("sat1");
    chk("sat1 oData4", 64'(bus4.oData), 64'h7777);
    chk("sat1 oData8", 64'(bus8.oData), 64'h0E0E0E0E);
    epoch("sat2");
    chk("sat2 oData4", 64'(bus4.oData), 64'h7777);
    chk("sat2 oData8", 64'(bus8.oData), 64'h1C1C1C1C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
